// File: rtl/bsram_port_arbiter_pkg.sv
// Shared types and defaults for the two-port BSRAM bank arbiter.
// Holds the FSM state encoding, the port ids and the default bank widths.
package bsram_port_arbiter_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_CLKHI = 2'd2,
        ST_CLKLO = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/bsram_port_arbiter_if.sv
// Requester-side bus of one BSRAM port: level request held until a one-cycle ack.
// master = the requester, slave = the arbiter.
interface bsram_port_arbiter_if
    import bsram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/bsram_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the port that did not win the previous grant.
module rr_arb2
    import bsram_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output logic       grant_valid,
    output port_id_t   grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = PORT_A;
        case (req)
            2'b01:   grant_id = PORT_A;
            2'b10:   grant_id = PORT_B;
            2'b11:   grant_id = other_port(last_grant);
            default: grant_id = PORT_A;
        endcase
    end

endmodule

// File: rtl/bsram_port_arbiter.sv
// Shares one single-port BSRAM bank between the host port (A) and the engine port (B),
// running setup -> mem_clk high -> mem_clk low + capture, four cycles per access.
module bsram_port_arbiter
    import bsram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                sysclk,
    input  logic                reset,
    bsram_port_arbiter_if.slave port_a,
    bsram_port_arbiter_if.slave port_b,
    input  logic [DATA_W-1:0]   mem_dout,
    output logic [ADDR_W-1:0]   mem_ad,
    output logic [DATA_W-1:0]   mem_din,
    output logic                mem_ce,
    output logic                mem_wre,
    output logic                mem_oce,
    output logic                mem_clk
);

    state_t            state_q, state_d;
    port_id_t          last_grant_q, last_grant_d;
    port_id_t          win_id_q, win_id_d;
    logic              we_q, we_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [ADDR_W-1:0] mem_ad_d;
    logic [DATA_W-1:0] mem_din_d;
    logic              mem_ce_d, mem_wre_d, mem_oce_d, mem_clk_d;

    logic              grant_valid;
    port_id_t          grant_id;

    // A port whose ack is high is finishing; it re-enters arbitration next IDLE.
    rr_arb2 u_arb (
        .req         ({port_b.req & ~b_ack_q, port_a.req & ~a_ack_q}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign port_a.ack   = a_ack_q;
    assign port_a.rdata = a_rdata_q;
    assign port_b.ack   = b_ack_q;
    assign port_b.rdata = b_rdata_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one
        // unassigned; an unassigned path in combinational logic infers a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_id_d     = win_id_q;
        we_d         = we_q;
        mem_ad_d     = mem_ad;
        mem_din_d    = mem_din;
        mem_ce_d     = mem_ce;
        mem_wre_d    = mem_wre;
        mem_oce_d    = mem_oce;
        mem_clk_d    = mem_clk;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d      = ST_SETUP;
                    last_grant_d = grant_id;
                    win_id_d     = grant_id;
                    if (grant_id == PORT_A) begin
                        we_d      = port_a.we;
                        mem_ad_d  = port_a.addr;
                        mem_din_d = port_a.wdata;
                    end else begin
                        we_d      = port_b.we;
                        mem_ad_d  = port_b.addr;
                        mem_din_d = port_b.wdata;
                    end
                    mem_ce_d  = 1'b1;
                    mem_wre_d = we_d;
                    mem_oce_d = ~we_d;
                end
            end
            ST_SETUP: begin
                mem_clk_d = 1'b1;
                state_d   = ST_CLKHI;
            end
            ST_CLKHI: begin
                mem_clk_d = 1'b0;
                mem_ce_d  = 1'b0;
                mem_wre_d = 1'b0;
                mem_oce_d = 1'b0;
                // Bank output is valid one fabric cycle after the mem_clk rising edge.
                if (win_id_q == PORT_A) begin
                    a_ack_d = 1'b1;
                    if (!we_q) a_rdata_d = mem_dout;
                end else begin
                    b_ack_d = 1'b1;
                    if (!we_q) b_rdata_d = mem_dout;
                end
                state_d = ST_CLKLO;
            end
            ST_CLKLO: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset with last_grant at B so port A holds tie priority out of reset.
    always_ff @(posedge sysclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_B;
            win_id_q     <= PORT_A;
            we_q         <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            mem_ad       <= '0;
            mem_din      <= '0;
            mem_ce       <= 1'b0;
            mem_wre      <= 1'b0;
            mem_oce      <= 1'b0;
            mem_clk      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_id_q     <= win_id_d;
            we_q         <= we_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            mem_ad       <= mem_ad_d;
            mem_din      <= mem_din_d;
            mem_ce       <= mem_ce_d;
            mem_wre      <= mem_wre_d;
            mem_oce      <= mem_oce_d;
            mem_clk      <= mem_clk_d;
        end
    end

endmodule

// File: tb/tb_bsram_port_arbiter.sv
// Directed bench for bsram_port_arbiter: reset abort, write/read, latching,
// round-robin alternation and back-to-back accesses against a small BSRAM model.
module tb_bsram_port_arbiter;
    import bsram_port_arbiter_pkg::*;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [7:0]  mem_dout;
    logic [13:0] mem_ad;
    logic [7:0]  mem_din;
    logic        mem_ce, mem_wre, mem_oce, mem_clk;

    int vectors     = 0;
    int miscompares = 0;

    bsram_port_arbiter_if #(.ADDR_W(14), .DATA_W(8)) port_a ();
    bsram_port_arbiter_if #(.ADDR_W(14), .DATA_W(8)) port_b ();

    bsram_port_arbiter #(.ADDR_W(14), .DATA_W(8)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .port_a   (port_a.slave),
        .port_b   (port_b.slave),
        .mem_dout (mem_dout),
        .mem_ad   (mem_ad),
        .mem_din  (mem_din),
        .mem_ce   (mem_ce),
        .mem_wre  (mem_wre),
        .mem_oce  (mem_oce),
        .mem_clk  (mem_clk)
    );

    always #5 sysclk = ~sysclk;

    // Single-port BSRAM: write or registered read on the rising edge of mem_clk.
    logic [7:0] mem [0:16383];
    always @(posedge mem_clk) begin
        if (mem_ce) begin
            if (mem_wre) mem[mem_ad] = mem_din;
            else if (mem_oce) mem_dout <= mem[mem_ad];
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ce"},  32'(mem_ce),  32'h0);
        check({tag, "_wre"}, 32'(mem_wre), 32'h0);
        check({tag, "_oce"}, 32'(mem_oce), 32'h0);
        check({tag, "_clk"}, 32'(mem_clk), 32'h0);
        check({tag, "_ad"},  32'(mem_ad),  32'h0);
        check({tag, "_din"}, 32'(mem_din), 32'h0);
        check({tag, "_aack"}, 32'(port_a.ack), 32'h0);
        check({tag, "_back"}, 32'(port_b.ack), 32'h0);
        check({tag, "_ardata"}, 32'(port_a.rdata), 32'h0);
        check({tag, "_brdata"}, 32'(port_b.rdata), 32'h0);
        check({tag, "_state"}, 32'(dut.state_q), 32'(ST_IDLE));
    endtask

    initial begin
        reset = 1'b1;
        mem_dout = 8'h00;
        port_a.req = 1'b0; port_a.we = 1'b0; port_a.addr = '0; port_a.wdata = '0;
        port_b.req = 1'b0; port_b.we = 1'b0; port_b.addr = '0; port_b.wdata = '0;

        // Reset state
        tick(3);
        check_idle_zero("rst_hold");
        reset = 1'b0;
        tick();
        check_idle_zero("rst_rel");

        // A write 0x0123 <- 0x5A
        port_a.req = 1'b1; port_a.we = 1'b1; port_a.addr = 14'h0123; port_a.wdata = 8'h5A;
        tick();
        check("aw_setup_ce",  32'(mem_ce),  32'h1);
        check("aw_setup_wre", 32'(mem_wre), 32'h1);
        check("aw_setup_oce", 32'(mem_oce), 32'h0);
        check("aw_setup_ad",  32'(mem_ad),  32'h0123);
        check("aw_setup_din", 32'(mem_din), 32'h5A);
        check("aw_setup_clk", 32'(mem_clk), 32'h0);
        check("aw_setup_ack", 32'(port_a.ack), 32'h0);
        tick();
        check("aw_clkhi_clk", 32'(mem_clk), 32'h1);
        check("aw_clkhi_wre", 32'(mem_wre), 32'h1);
        check("aw_clkhi_ack", 32'(port_a.ack), 32'h0);
        tick();
        check("aw_ack",       32'(port_a.ack), 32'h1);
        check("aw_back",      32'(port_b.ack), 32'h0);
        check("aw_clklo_clk", 32'(mem_clk), 32'h0);
        check("aw_clklo_ce",  32'(mem_ce),  32'h0);
        check("aw_clklo_wre", 32'(mem_wre), 32'h0);
        check("aw_rdata",     32'(port_a.rdata), 32'h00);
        port_a.req = 1'b0;
        tick();
        check("aw_ack_drop", 32'(port_a.ack), 32'h0);
        check("aw_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // A read 0x0123 -> 0x5A
        port_a.req = 1'b1; port_a.we = 1'b0; port_a.addr = 14'h0123;
        tick();
        check("ar_oce", 32'(mem_oce), 32'h1);
        check("ar_wre", 32'(mem_wre), 32'h0);
        tick(2);
        check("ar_ack",   32'(port_a.ack), 32'h1);
        check("ar_rdata", 32'(port_a.rdata), 32'h5A);
        port_a.req = 1'b0;
        tick();

        // A write 0x0AAA <- 0x3C while addr/wdata wander after IDLE
        port_a.req = 1'b1; port_a.we = 1'b1; port_a.addr = 14'h0AAA; port_a.wdata = 8'h3C;
        tick();
        port_a.addr = 14'h1555; port_a.wdata = 8'hFF;
        tick();
        check("lat_clkhi_ad",  32'(mem_ad),  32'h0AAA);
        check("lat_clkhi_din", 32'(mem_din), 32'h3C);
        port_a.addr = 14'h0000; port_a.wdata = 8'h00;
        tick();
        check("lat_ack",      32'(port_a.ack), 32'h1);
        check("lat_clklo_ad", 32'(mem_ad), 32'h0AAA);
        port_a.req = 1'b0;
        tick();

        // A write 0x0010 <- 0xC3 (used by the port B read later)
        port_a.req = 1'b1; port_a.we = 1'b1; port_a.addr = 14'h0010; port_a.wdata = 8'hC3;
        tick(3);
        check("pre_ack", 32'(port_a.ack), 32'h1);
        port_a.req = 1'b0;
        tick();

        // Reset held 3 cycles while an A read sits in CLK_HI
        port_a.req = 1'b1; port_a.we = 1'b0; port_a.addr = 14'h0123;
        tick(2);
        check("ra_clkhi", 32'(dut.state_q), 32'(ST_CLKHI));
        reset = 1'b1;
        port_a.req = 1'b0;
        tick();
        check("ra_first_ack", 32'(port_a.ack), 32'h0);
        check("ra_first_clk", 32'(mem_clk), 32'h0);
        tick(2);
        reset = 1'b0;
        check_idle_zero("ra_hold");
        tick();
        check_idle_zero("ra_rel");

        // A and B request together: A first, then alternate A,B,A,B
        port_a.req = 1'b1; port_a.we = 1'b0; port_a.addr = 14'h0123;
        port_b.req = 1'b1; port_b.we = 1'b0; port_b.addr = 14'h0AAA;
        tick();
        check("rr1_ad", 32'(mem_ad), 32'h0123);
        tick(2);
        check("rr1_aack",  32'(port_a.ack), 32'h1);
        check("rr1_back",  32'(port_b.ack), 32'h0);
        check("rr1_rdata", 32'(port_a.rdata), 32'h5A);
        tick(2);
        check("rr2_ad", 32'(mem_ad), 32'h0AAA);
        tick(2);
        check("rr2_back",  32'(port_b.ack), 32'h1);
        check("rr2_aack",  32'(port_a.ack), 32'h0);
        check("rr2_rdata", 32'(port_b.rdata), 32'h3C);
        tick(2);
        check("rr3_ad", 32'(mem_ad), 32'h0123);
        tick(2);
        check("rr3_aack", 32'(port_a.ack), 32'h1);
        check("rr3_back", 32'(port_b.ack), 32'h0);
        tick(2);
        check("rr4_ad", 32'(mem_ad), 32'h0AAA);
        tick(2);
        check("rr4_back", 32'(port_b.ack), 32'h1);
        check("rr4_aack", 32'(port_a.ack), 32'h0);
        port_a.req = 1'b0; port_b.req = 1'b0;
        tick();

        // B only, req held: writes to 0x3FFF, 0x0000, 0x2000 four cycles apart
        port_b.req = 1'b1; port_b.we = 1'b1; port_b.addr = 14'h3FFF; port_b.wdata = 8'h11;
        tick();
        check("b3_ad0",  32'(mem_ad),  32'h3FFF);
        check("b3_wre0", 32'(mem_wre), 32'h1);
        tick(2);
        check("b3_ack0", 32'(port_b.ack), 32'h1);
        port_b.addr = 14'h0000; port_b.wdata = 8'h22;
        tick();
        check("b3_gap", 32'(port_b.ack), 32'h0);
        tick();
        check("b3_ad1", 32'(mem_ad), 32'h0000);
        tick(2);
        check("b3_ack1", 32'(port_b.ack), 32'h1);
        port_b.addr = 14'h2000; port_b.wdata = 8'h33;
        tick(2);
        check("b3_ad2", 32'(mem_ad), 32'h2000);
        tick(2);
        check("b3_ack2",  32'(port_b.ack), 32'h1);
        check("b3_rdata", 32'(port_b.rdata), 32'h3C);
        port_b.req = 1'b0;
        tick();

        // B read 0x0010 (0xC3), then B write 0x77 back-to-back
        port_b.req = 1'b1; port_b.we = 1'b0; port_b.addr = 14'h0010;
        tick(3);
        check("brw_rack",  32'(port_b.ack), 32'h1);
        check("brw_rdata", 32'(port_b.rdata), 32'hC3);
        port_b.we = 1'b1; port_b.wdata = 8'h77;
        tick(2);
        check("brw_wre", 32'(mem_wre), 32'h1);
        check("brw_din", 32'(mem_din), 32'h77);
        tick(2);
        check("brw_wack",   32'(port_b.ack), 32'h1);
        check("brw_hold",   32'(port_b.rdata), 32'hC3);
        check("brw_ardata", 32'(port_a.rdata), 32'h5A);
        port_b.req = 1'b0;
        tick();

        // A reads back what B wrote at the top of the space and at 0x0010
        port_a.req = 1'b1; port_a.we = 1'b0; port_a.addr = 14'h3FFF;
        tick(3);
        check("top_ack",   32'(port_a.ack), 32'h1);
        check("top_rdata", 32'(port_a.rdata), 32'h11);
        port_a.addr = 14'h0010;
        tick(4);
        check("ovr_ack",   32'(port_a.ack), 32'h1);
        check("ovr_rdata", 32'(port_a.rdata), 32'h77);
        check("ovr_brdata", 32'(port_b.rdata), 32'hC3);
        port_a.req = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
